// File: rtl/apb_bridge_pkg.sv
// Shared types and helpers for the APB master bridge.
// FSM state, response bundle and width helper.
package apb_bridge_pkg;

  localparam int unsigned MAX_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_e;

  typedef struct packed {
    logic [MAX_DATA_W-1:0] rdata;
    logic                  master_error;
    logic                  other_error;
  } rsp_t;

  // Index width for n items, never below 1 so single-item cases still get a bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/apb_master_bridge_decode.sv
// Address decoder for the APB master bridge.
// Maps a byte address to slave index, hit flag and one-hot select.
module apb_addr_decode
  import apb_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned NUM_SLAVES      = 4,
  parameter int unsigned SLAVE_ADDR_BITS = 12,
  parameter int unsigned IDX_W           = clog2(NUM_SLAVES)
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  hit_o,
  output logic [IDX_W-1:0]      idx_o,
  output logic [NUM_SLAVES-1:0] sel_o
);

  logic [ADDR_WIDTH-1:0] slot;

  assign slot  = addr_i >> SLAVE_ADDR_BITS;
  assign hit_o = slot < ADDR_WIDTH'(NUM_SLAVES);
  assign idx_o = slot[IDX_W-1:0];

  always_comb begin
    sel_o = '0;
    if (hit_o) begin
      sel_o = NUM_SLAVES'(1) << idx_o;
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// APB master bridge: one valid/ready command at a time,
// SETUP/ACCESS sequencing, wait-state timeout, registered response.
module apb_master_bridge
  import apb_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned NUM_SLAVES      = 4,
  parameter int unsigned SLAVE_ADDR_BITS = 12,
  parameter int unsigned TIMEOUT_CYCLES  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_write,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [DATA_WIDTH-1:0]            req_wdata,
  input  logic [DATA_WIDTH/8-1:0]          req_strb,
  input  logic [2:0]                       req_prot,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_master_error,
  output logic                             rsp_other_error,
  output logic [ADDR_WIDTH-1:0]            paddr,
  output logic [NUM_SLAVES-1:0]            psel,
  output logic                             penable,
  output logic                             pwrite,
  output logic [DATA_WIDTH-1:0]            pwdata,
  output logic [DATA_WIDTH/8-1:0]          pstrb,
  output logic [2:0]                       pprot,
  input  logic [NUM_SLAVES-1:0]            pready,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]            pslverr
);

  localparam int unsigned SW      = DATA_WIDTH / 8;
  localparam int unsigned IW      = clog2(NUM_SLAVES);
  localparam int unsigned CW      = clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned TO_LAST =
    (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  state_e                  state_q;
  logic [IW-1:0]           idx_q;
  logic [CW-1:0]           cnt_q;
  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic [NUM_SLAVES-1:0]   psel_q;
  logic                    penable_q;
  logic                    pwrite_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic [SW-1:0]           pstrb_q;
  logic [2:0]              pprot_q;
  rsp_t                    rsp_q;
  rsp_t                    rsp_d;

  logic                    dec_hit;
  logic [IW-1:0]           dec_idx;
  logic [NUM_SLAVES-1:0]   dec_sel;
  logic                    accept;
  logic                    sel_ready;
  logic                    sel_err;
  logic [DATA_WIDTH-1:0]   sel_rdata;
  logic                    timeout_hit;
  logic [SW-1:0]           strb_d;
  logic [2:0]              prot_d;

  apb_addr_decode #(
    .ADDR_WIDTH      (ADDR_WIDTH),
    .NUM_SLAVES      (NUM_SLAVES),
    .SLAVE_ADDR_BITS (SLAVE_ADDR_BITS),
    .IDX_W           (IW)
  ) u_decode (
    .addr_i (req_addr),
    .hit_o  (dec_hit),
    .idx_o  (dec_idx),
    .sel_o  (dec_sel)
  );

  // A response being consumed frees the bridge in the same cycle.
  assign req_ready = (state_q == IDLE) ||
                     ((state_q == RESP) && rsp_ready);
  assign accept    = req_valid && req_ready;

`ifdef APB_WSTRB
  assign strb_d = req_write ? req_strb : '0;
`else
  assign strb_d = '0;
`endif

`ifdef APB_PROT
  assign prot_d = req_prot;
`else
  assign prot_d = '0;
`endif

  logic unused_attr;
  assign unused_attr = ^{req_strb, req_prot};

  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == IW'(i)) begin
        sel_ready = pready[i];
        sel_err   = pslverr[i];
        sel_rdata = prdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       (cnt_q == CW'(TO_LAST));

  // Completion beats timeout when both land on the same cycle.
  always_comb begin
    rsp_d = '0;
    if (sel_ready) begin
      rsp_d.other_error = sel_err;
      if (!pwrite_q && !sel_err) begin
        rsp_d.rdata[DATA_WIDTH-1:0] = sel_rdata;
      end
    end else begin
      rsp_d.master_error = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      paddr_q   <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      pprot_q   <= '0;
      rsp_q     <= '0;
    end else if (accept) begin
      cnt_q <= '0;
      if (dec_hit) begin
        state_q   <= SETUP;
        idx_q     <= dec_idx;
        psel_q    <= dec_sel;
        penable_q <= 1'b0;
        paddr_q   <= req_addr;
        pwrite_q  <= req_write;
        pwdata_q  <= req_wdata;
        pstrb_q   <= strb_d;
        pprot_q   <= prot_d;
        rsp_q     <= '0;
      end else begin
        state_q <= RESP;
        rsp_q   <= '{rdata: '0, master_error: 1'b1,
                     other_error: 1'b0};
      end
    end else begin
      unique case (state_q)
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (sel_ready || timeout_hit) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            rsp_q     <= rsp_d;
            state_q   <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid        = (state_q == RESP);
  assign rsp_rdata        = rsp_q.rdata[DATA_WIDTH-1:0];
  assign rsp_master_error = rsp_q.master_error;
  assign rsp_other_error  = rsp_q.other_error;
  assign paddr            = paddr_q;
  assign psel             = psel_q;
  assign penable          = penable_q;
  assign pwrite           = pwrite_q;
  assign pwdata           = pwdata_q;
  assign pstrb            = pstrb_q;
  assign pprot            = pprot_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge with a
// randomized slave model and transaction-level reference.
module tb_apb_master_bridge;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int NS  = 4;
  localparam int SAB = 12;
  localparam int TO  = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [AW-1:0]   req_addr;
  logic [DW-1:0]   req_wdata;
  logic [DW/8-1:0] req_strb;
  logic [2:0]      req_prot;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_master_error;
  logic            rsp_other_error;
  logic [AW-1:0]   paddr;
  logic [NS-1:0]   psel;
  logic            penable;
  logic            pwrite;
  logic [DW-1:0]   pwdata;
  logic [DW/8-1:0] pstrb;
  logic [2:0]      pprot;
  logic [NS-1:0]   pready;
  logic [NS*DW-1:0] prdata;
  logic [NS-1:0]   pslverr;

  int errors = 0;
  int checks = 0;

  // slave model configuration
  int          wait_cfg = 0;
  logic [31:0] rd_cfg   = '0;
  logic        err_cfg  = 1'b0;
  int          acc_cnt  = 0;

  // expected response of the most recent transaction
  logic [31:0] exp_rdata;
  logic        exp_me;
  logic        exp_oe;
  bit          rsp_pending = 0;

  always #5 clk = ~clk;

  apb_master_bridge #(
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .NUM_SLAVES      (NS),
    .SLAVE_ADDR_BITS (SAB),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .req_strb         (req_strb),
    .req_prot         (req_prot),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_rdata        (rsp_rdata),
    .rsp_master_error (rsp_master_error),
    .rsp_other_error  (rsp_other_error),
    .paddr            (paddr),
    .psel             (psel),
    .penable          (penable),
    .pwrite           (pwrite),
    .pwdata           (pwdata),
    .pstrb            (pstrb),
    .pprot            (pprot),
    .pready           (pready),
    .prdata           (prdata),
    .pslverr          (pslverr)
  );

  // Slaves: noise everywhere, selected slave answers after wait_cfg
  // ACCESS cycles; its pslverr is noise until pready.
  always @(negedge clk) begin
    prdata  = {$urandom, $urandom, $urandom, $urandom};
    pready  = NS'($urandom);
    pslverr = NS'($urandom);
    if (penable && psel != '0) begin
      for (int i = 0; i < NS; i++) begin
        if (psel[i]) begin
          pready[i] = (acc_cnt >= wait_cfg);
          if (pready[i]) begin
            pslverr[i] = err_cfg;
            prdata[i*DW +: DW] = rd_cfg;
          end
        end
      end
      acc_cnt++;
    end else begin
      acc_cnt = 0;
    end
  end

  task automatic issue(input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input int waits,
                       input logic [31:0] rd, input logic err);
    int          idx;
    bit          hit;
    bit          tmo;
    int          lat_exp;
    int          edges;
    logic [NS-1:0] sel_exp;
    idx     = int'(addr / (32'd1 << SAB));
    hit     = idx < NS;
    tmo     = hit && (waits >= TO);
    sel_exp = hit ? NS'(1 << idx) : '0;
    lat_exp = !hit ? 1 : (tmo ? 2 + TO : 3 + waits);
    exp_me    = !hit || tmo;
    exp_oe    = hit && !tmo && err;
    exp_rdata = (hit && !tmo && !wr && !err) ? rd : 32'h0;

    @(negedge clk);
    wait_cfg  = waits;
    rd_cfg    = rd;
    err_cfg   = err;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_strb  = 4'($urandom);
    req_prot  = 3'($urandom);
    if (rsp_pending) rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1)
      $display("FAIL accept_ready addr=%h: req_ready=%b want 1",
               addr, req_ready);
    if (req_ready !== 1'b1) errors++;
    @(posedge clk);
    #1;
    req_valid   = 1'b0;
    rsp_ready   = 1'b0;
    rsp_pending = 0;
    edges       = 1;
    while (rsp_valid !== 1'b1 && edges < 100) begin
      checks++;
      if (psel !== sel_exp || penable !== (edges >= 2) ||
          paddr !== addr || pwrite !== wr ||
          (wr && pwdata !== wdata) || (!wr && pstrb !== '0)) begin
        errors++;
        $display("FAIL apb_phase addr=%h edge=%0d: psel=%b pen=%b paddr=%h pwrite=%b want psel=%b pen=%b",
                 addr, edges, psel, penable, paddr, pwrite,
                 sel_exp, (edges >= 2));
      end
      @(posedge clk);
      #1;
      edges++;
    end
    checks++;
    if (edges !== lat_exp) begin
      errors++;
      $display("FAIL latency addr=%h: edges=%0d want %0d",
               addr, edges, lat_exp);
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rdata ||
        rsp_master_error !== exp_me || rsp_other_error !== exp_oe ||
        psel !== '0 || penable !== 1'b0) begin
      errors++;
      $display("FAIL response addr=%h: v=%b rd=%h me=%b oe=%b psel=%b pen=%b want rd=%h me=%b oe=%b",
               addr, rsp_valid, rsp_rdata, rsp_master_error,
               rsp_other_error, psel, penable, exp_rdata, exp_me, exp_oe);
    end
    rsp_pending = 1;
  endtask

  task automatic hold_rsp(input int n);
    for (int h = 0; h < n; h++) begin
      @(negedge clk);
      rsp_ready = 1'b0;
      #1;
      checks++;
      if (req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_ready: req_ready=%b want 0", req_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rdata ||
          rsp_master_error !== exp_me || rsp_other_error !== exp_oe) begin
        errors++;
        $display("FAIL hold_stable: v=%b rd=%h me=%b oe=%b want 1 %h %b %b",
                 rsp_valid, rsp_rdata, rsp_master_error,
                 rsp_other_error, exp_rdata, exp_me, exp_oe);
      end
    end
  endtask

  task automatic release_rsp();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready   = 1'b0;
    rsp_pending = 0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL release: rsp_valid=%b req_ready=%b want 0 1",
               rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
         rsp_rdata, rsp_master_error, rsp_other_error,
         rsp_valid} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: paddr=%h psel=%b pen=%b rsp_valid=%b rd=%h want all 0",
               paddr, psel, penable, rsp_valid, rsp_rdata);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: req_ready=%b want 1", req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write();
    issue(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 0, 32'h0, 1'b0);
    release_rsp();
  endtask

  task automatic test_wait_read();
    issue(1'b0, 32'h0000_2010, 32'h0, 3, 32'h1234_5678, 1'b0);
    hold_rsp(1);
    release_rsp();
  endtask

  task automatic test_decode_miss();
    issue(1'b0, 32'h0000_5000, 32'h0, 0, 32'hFFFF_FFFF, 1'b0);
    release_rsp();
  endtask

  task automatic test_timeout();
    issue(1'b0, 32'h0000_0040, 32'h0, 1000, 32'hAAAA_5555, 1'b0);
    release_rsp();
    issue(1'b0, 32'h0000_0080, 32'h0, TO - 1, 32'h0BAD_F00D, 1'b0);
    release_rsp();
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 32'h0000_3008, 32'h5A5A_A5A5, 0, 32'h0, 1'b1);
    hold_rsp(4);
    issue(1'b0, 32'h0000_100C, 32'h0, 1, 32'hCAFE_0001, 1'b0);
    issue(1'b0, 32'h0000_7000, 32'h0, 0, 32'h0, 1'b0);
    issue(1'b0, 32'h0000_0004, 32'h0, 0, 32'h0000_0042, 1'b0);
    release_rsp();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    wait_cfg  = 1000;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h0000_1000;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (penable !== 1'b1 || psel !== 4'b0010) begin
      errors++;
      $display("FAIL mid_access: pen=%b psel=%b want 1 0010",
               penable, psel);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (psel !== '0 || penable !== 1'b0 || rsp_valid !== 1'b0 ||
        req_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: psel=%b pen=%b rsp_valid=%b req_ready=%b want 0 0 0 1",
               psel, penable, rsp_valid, req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int          slot;
      int          waits;
      logic [31:0] addr;
      slot  = $urandom_range(0, 5);
      addr  = (32'(slot) << SAB) | (32'($urandom_range(0, 1023)) << 2);
      case ($urandom_range(0, 9))
        0:       waits = TO + $urandom_range(0, 2);
        1:       waits = TO - 1;
        default: waits = $urandom_range(0, 4);
      endcase
      issue(1'($urandom), addr, $urandom, waits, $urandom,
            ($urandom_range(0, 3) == 0));
      case ($urandom_range(0, 2))
        0: ;
        1: begin
          hold_rsp($urandom_range(0, 2));
          release_rsp();
        end
        default: release_rsp();
      endcase
    end
    if (rsp_pending) release_rsp();
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_strb  = '0;
    req_prot  = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_write();
    test_wait_read();
    test_decode_miss();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
